// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I load/store constants and lane helpers for the data-memory path.
//   XLEN            data path width
//   F3_*            funct3 encodings of the RV32I loads and stores
//   alignOff()      offset with the bits below the access size forced to zero
//   byteEnable()    store byte-lane enables for a funct3/offset pair
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] is the size code for loads and stores alike.
    function automatic logic [1:0] alignOff(logic [2:0] funct3, logic [1:0] off);
        return (funct3[1:0] == F3_LW[1:0]) ? 2'b00 : (funct3[1:0] == F3_LH[1:0]) ? {off[1], 1'b0} : off;
    endfunction

    function automatic logic [3:0] byteEnable(logic [2:0] funct3, logic [1:0] off);
        return ((funct3 == F3_SB) ? 4'b0001 : (funct3 == F3_SH) ? 4'b0011 : 4'b1111) << off;
    endfunction
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: single-port word SRAM, synchronous read, per-byte write enables.
//   clk    clock, rising edge
//   we     write strobe (uses be/wdata at addr)
//   re     read strobe (rdata updates at the edge)
//   addr   word index
//   be     byte-lane write enables
//   wdata  lane-aligned write data
//   rdata  registered read data
module dmem_sram
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic            clk,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [3:0]      be,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[addr];
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder, one-entry store buffer with byte-wise load merge.
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ALU_MemReq_1        request valid          ALU_MemWen_1      1 = store, 0 = load
//   ALU_Funct3_3        RV32I funct3           ALU_MemAddr_32    byte address
//   ALU_StoreData_32    store data in the low bits
//   MEM_LoadValid_1     one-cycle load response pulse, one cycle after the request
//   MEM_LoadData_32     aligned, sign/zero-extended load result (0 when not valid)
//   MEM_AccessErr_1     misaligned-access pulse (only with DMEM_MISALIGN_TRAP_EN)
//   StoreBufPending_1   store buffer occupied
// Build option DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged
// instead of having their low offset bits forced to zero.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ALU_MemReq_1,
    input  logic        ALU_MemWen_1,
    input  logic [2:0]  ALU_Funct3_3,
    input  logic [31:0] ALU_MemAddr_32,
    input  logic [31:0] ALU_StoreData_32,
    output logic        MEM_LoadValid_1,
    output logic [31:0] MEM_LoadData_32,
    output logic        MEM_AccessErr_1,
    output logic        StoreBufPending_1
);
    logic [AW-1:0]   reqIdx, bufIdx, sramIdx;
    logic [1:0]      reqOff, respOff;
    logic [3:0]      reqBe, bufBe, snapBe;
    logic [XLEN-1:0] reqData, bufData, snapData, rdData, merged, shifted, extData;
    logic [2:0]      respFunct3;
    logic            misalign, loadReq, storeReq, drain, bufValid, respValid, respErr;
    logic            unusedAddr;

    // Address bits above the array simply wrap.
    assign unusedAddr = ^ALU_MemAddr_32[31:AW+2];
    assign reqIdx     = ALU_MemAddr_32[AW+1:2];
    assign reqOff     = alignOff(ALU_Funct3_3, ALU_MemAddr_32[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ALU_Funct3_3[1] ? |ALU_MemAddr_32[1:0] : ALU_Funct3_3[0] & ALU_MemAddr_32[0];
`else
    assign misalign = 1'b0;
`endif
    assign loadReq  = ALU_MemReq_1 & ~ALU_MemWen_1 & ~misalign;
    assign storeReq = ALU_MemReq_1 & ALU_MemWen_1 & ~misalign;
    // Loads own the port; the buffer drains on any cycle without one.
    assign drain    = bufValid & ~loadReq;
    assign reqBe    = byteEnable(ALU_Funct3_3, reqOff);
    assign reqData  = ALU_StoreData_32 << {reqOff, 3'b000};
    assign sramIdx  = loadReq ? reqIdx : bufIdx;

    dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) uSram (
        .clk   (clk),
        .we    (drain),
        .re    (loadReq),
        .addr  (sramIdx),
        .be    (bufBe),
        .wdata (bufData),
        .rdata (rdData)
    );

    // A new store replaces a draining entry at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufValid <= 1'b0;
            bufIdx   <= '0;
            bufBe    <= '0;
            bufData  <= '0;
        end else if (storeReq) begin
            bufValid <= 1'b1;
            bufIdx   <= reqIdx;
            bufBe    <= reqBe;
            bufData  <= reqData;
        end else if (drain) begin
            bufValid <= 1'b0;
        end
    end

    // Buffer bytes are snapshotted alongside the array read so the merge sees
    // the buffer as it stood when the load was sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            respValid  <= 1'b0;
            respErr    <= 1'b0;
            respFunct3 <= '0;
            respOff    <= '0;
            snapBe     <= '0;
            snapData   <= '0;
        end else begin
            respValid <= ALU_MemReq_1 & ~ALU_MemWen_1;
            respErr   <= ALU_MemReq_1 & misalign;
            if (loadReq) begin
                respFunct3 <= ALU_Funct3_3;
                respOff    <= reqOff;
                snapBe     <= (bufValid && bufIdx == reqIdx) ? bufBe : 4'b0000;
                snapData   <= bufData;
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : gMerge
        assign merged[8*b +: 8] = snapBe[b] ? snapData[8*b +: 8] : rdData[8*b +: 8];
    end

    assign shifted = merged >> {respOff, 3'b000};

    always_comb begin
        extData = (respFunct3 == F3_LB)  ? {{24{shifted[7]}}, shifted[7:0]} :
                  (respFunct3 == F3_LBU) ? {24'd0, shifted[7:0]} :
                  (respFunct3 == F3_LH)  ? {{16{shifted[15]}}, shifted[15:0]} :
                  (respFunct3 == F3_LHU) ? {16'd0, shifted[15:0]} : shifted;
    end

    assign MEM_LoadValid_1   = respValid;
    assign MEM_LoadData_32   = (respValid & ~respErr) ? extData : '0;
    assign MEM_AccessErr_1   = respErr;
    assign StoreBufPending_1 = bufValid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wen = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0, sdata = '0;
    logic        lv, err, pend;
    logic [31:0] ld;
    int          checks = 0, errors = 0, cyc = 0;
    logic [7:0]  refMem [0:4095];

    typedef struct {
        int          due;
        bit          isLoad;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    exp_t e;

    dmem_responder dut (
        .clk               (clk),
        .rst               (rst),
        .ALU_MemReq_1      (req),
        .ALU_MemWen_1      (wen),
        .ALU_Funct3_3      (f3),
        .ALU_MemAddr_32    (addr),
        .ALU_StoreData_32  (sdata),
        .MEM_LoadValid_1   (lv),
        .MEM_LoadData_32   (ld),
        .MEM_AccessErr_1   (err),
        .StoreBufPending_1 (pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int eOff(logic [2:0] f, logic [1:0] o);
        return f[1] ? 0 : f[0] ? int'(o & 2'b10) : int'(o);
    endfunction

    function automatic bit misal(logic [2:0] f, logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return f[1] ? (a[1:0] != 2'b00) : (f[0] & a[0]);
`else
        return 1'b0;
`endif
    endfunction

    // Memory is a flat byte array; the store buffer is invisible at this level.
    function automatic logic [31:0] modelLoad(logic [2:0] f, logic [31:0] a);
        int n = 1 << f[1:0];
        int b = int'(a & 32'hFFC) + eOff(f, a[1:0]);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[(b + i) & 12'hFFF];
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic modelStore(logic [2:0] f, logic [31:0] a, logic [31:0] d);
        int n = 1 << f[1:0];
        int b = int'(a & 32'hFFC) + eOff(f, a[1:0]);
        for (int i = 0; i < n; i++) refMem[(b + i) & 12'hFFF] = d[8*i +: 8];
    endtask

    task automatic op(bit r, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        bit m;
        req = r; wen = w; f3 = f; addr = a; sdata = d;
        m = misal(f, a);
        if (r && !w) q.push_back('{cyc + 1, 1'b1, m, m ? 32'd0 : modelLoad(f, a)});
        if (r && w) begin
            if (m) q.push_back('{cyc + 1, 1'b0, 1'b1, 32'd0});
            else modelStore(f, a, d);
        end
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (lv || err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp valid=%b err=%b data=%h", lv, err, ld);
                end else begin
                    e = q.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("resp_valid", {31'd0, lv}, {31'd0, e.isLoad});
                    check("resp_err", {31'd0, err}, {31'd0, e.err});
                    check("resp_data", ld, e.data);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_resp got=none expected_cycle=%0d", q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int r;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, lv}, 32'd0);
        check("rst_data", ld, 32'd0);
        check("rst_pend", {31'd0, pend}, 32'd0);
        rst = 1'b0;
        for (int w = 0; w < 64; w++) op(1'b1, 1'b1, 3'b010, w * 4, $urandom);
        idle();

        // store, drain, read back
        op(1'b1, 1'b1, 3'b010, 32'h100, 32'h11223344);
        idle();
        check("t1_pend_drained", {31'd0, pend}, 32'd0);
        op(1'b1, 1'b0, 3'b010, 32'h100, 0);
        check("t1_lw", ld, 32'h11223344);

        // load hitting the still-full buffer
        op(1'b1, 1'b1, 3'b010, 32'h40, 32'hAABBCCDD);
        op(1'b1, 1'b0, 3'b000, 32'h43, 0);
        check("t2_lb", ld, 32'hFFFFFFAA);
        op(1'b1, 1'b0, 3'b100, 32'h43, 0);
        check("t2_lbu", ld, 32'h000000AA);

        // byte store merged into a halfword load, then array contents
        op(1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
        idle();
        op(1'b1, 1'b1, 3'b000, 32'h22, 32'h5A);
        op(1'b1, 1'b0, 3'b101, 32'h22, 0);
        check("t3_lhu", ld, 32'h0000005A);
        idle();
        op(1'b1, 1'b0, 3'b010, 32'h20, 0);
        check("t3_array", ld, 32'h005A0000);

        // back-to-back loads keep the buffer pending
        op(1'b1, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5);
        op(1'b1, 1'b1, 3'b010, 32'h4, 32'h0BADF00D);
        check("t4_pend_store", {31'd0, pend}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b0, 3'b010, 32'h4, 0);
            check("t4_lw", ld, 32'h0BADF00D);
            check("t4_pend_loads", {31'd0, pend}, 32'd1);
        end
        idle();
        check("t4_pend_idle", {31'd0, pend}, 32'd0);

        // misaligned accesses
        op(1'b1, 1'b0, 3'b010, 32'h102, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_data", ld, 32'd0);
        op(1'b1, 1'b1, 3'b001, 32'h101, 32'h1234);
        idle();
        op(1'b1, 1'b0, 3'b010, 32'h100, 0);
        check("t5_sh_suppressed", ld, 32'h11223344);
`else
        check("t5_lw_forced", ld, 32'h11223344);
        check("t5_err_tied", {31'd0, err}, 32'd0);
`endif

        // reset discards the buffered store
        idle();
        op(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("t6_pend", {31'd0, pend}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, lv}, 32'd0);
        check("t6_rst_err", {31'd0, err}, 32'd0);
        check("t6_rst_data", ld, 32'd0);
        check("t6_rst_pend", {31'd0, pend}, 32'd0);
        modelStore(3'b010, 32'h100, 32'h11223344);
        @(negedge clk);
        rst = 1'b0;
        op(1'b1, 1'b0, 3'b010, 32'h100, 0);
        check("t6_lw_old", ld, 32'h11223344);

        // random traffic in the initialised region
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) idle();
            else if (r < 6) op(1'b1, 1'b0, lf[$urandom_range(0, 4)], $urandom_range(0, 255), 0);
            else op(1'b1, 1'b1, 3'($urandom_range(0, 2)), $urandom_range(0, 255), $urandom);
        end
        repeat (3) idle();
        check("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
